// File: rtl/tcp_cks_pkg.sv
// tcp_cks_pkg
// Shared types and constants for the TCP checksum insertion path:
// stream widths, the buffered beat layout, the insertion FSM states,
// the default checksum byte lane and the helper that writes the
// checksum into a beat.
package tcp_cks_pkg;

    localparam int DATA_W             = 512;
    localparam int KEEP_W             = DATA_W / 8;
    // Ethernet header 14 B + IPv4 header 20 B + checksum offset 16 B in the TCP header
    localparam int DEFAULT_CKS_OFFSET = 50;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [KEEP_W-1:0] keep;
        logic              last;
    } beat_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HEAD = 2'd1,
        ST_BODY = 2'd2
    } state_e;

    // The engine sums little-endian lane pairs, so the low checksum byte
    // goes into the lower byte lane.
    function automatic logic [DATA_W-1:0] patchChecksum(
        input logic [DATA_W-1:0] data,
        input logic [15:0]       cks,
        input int                offset
    );
        logic [DATA_W-1:0] patched;
        patched                   = data;
        patched[8*offset +: 16]   = cks;
        return patched;
    endfunction

endpackage

// File: rtl/tcp_cks_beat_fifo.sv
// tcp_cks_beat_fifo
// First-word-fall-through synchronous FIFO of stream beats. The head
// beat is always visible on rdBeat_o while the FIFO is not empty. A
// write is accepted when not full, or when full together with a read in
// the same cycle.
// Ports:
//   clk_i, rst_i  clock and synchronous active-high reset (flushes pointers)
//   wrEn_i        write request, wrBeat_i the beat to store
//   full_o        no free entry
//   rdEn_i        pop the head beat
//   rdBeat_o      head beat (valid while empty_o is low)
//   empty_o       no stored beat
module tcp_cks_beat_fifo
    import tcp_cks_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  wrEn_i,
    input  beat_t wrBeat_i,
    output logic  full_o,
    input  logic  rdEn_i,
    output beat_t rdBeat_o,
    output logic  empty_o
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    beat_t       mem [DEPTH];
    logic [AW:0] wrPtr_q, wrPtr_d;
    logic [AW:0] rdPtr_q, rdPtr_d;
    logic        wrAccept;
    logic        rdAccept;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty_o  = (wrPtr_q == rdPtr_q);
    assign full_o   = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                      (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
    assign rdAccept = rdEn_i && !empty_o;
    assign wrAccept = wrEn_i && (!full_o || rdAccept);
    assign rdBeat_o = mem[rdPtr_q[AW-1:0]];

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        if (wrAccept) begin
            wrPtr_d = wrPtr_q + PTR_ONE;
        end
        if (rdAccept) begin
            rdPtr_d = rdPtr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wrAccept) begin
            mem[wrPtr_q[AW-1:0]] <= wrBeat_i;
        end
    end

endmodule

// File: rtl/tcp_checksum_insert.sv
// tcp_checksum_insert
// Buffers outgoing frames while the checksum engine works on the same
// beats, then writes the engine's checksum into the TCP checksum field
// of beat 0 and forwards the frame downstream.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   S_AXIS_*          incoming 512-bit frame stream (TREADY low when buffer full)
//   S_CKS_*           one checksum word per frame, in frame order
//   M_AXIS_*          patched outgoing frame stream (registered outputs)
//   pkt_count         number of frames fully emitted, wrapping
module tcp_checksum_insert
    import tcp_cks_pkg::*;
#(
    parameter int DEPTH      = 32,
    parameter int CKS_OFFSET = DEFAULT_CKS_OFFSET
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] S_AXIS_TDATA,
    input  logic [KEEP_W-1:0] S_AXIS_TKEEP,
    input  logic              S_AXIS_TVALID,
    input  logic              S_AXIS_TLAST,
    output logic              S_AXIS_TREADY,
    input  logic [15:0]       S_CKS_TDATA,
    input  logic              S_CKS_TVALID,
    output logic              S_CKS_TREADY,
    output logic [DATA_W-1:0] M_AXIS_TDATA,
    output logic [KEEP_W-1:0] M_AXIS_TKEEP,
    output logic              M_AXIS_TVALID,
    output logic              M_AXIS_TLAST,
    input  logic              M_AXIS_TREADY,
    output logic [31:0]       pkt_count
);

    localparam int CW = $clog2(DEPTH + 1);

    state_e        state_q, state_d;
    beat_t         outBeat_q, outBeat_d;
    logic          outValid_q, outValid_d;
    logic [31:0]   pktCount_q, pktCount_d;
    logic [CW-1:0] inBeats_q, inBeats_d;

    beat_t         inBeat;
    beat_t         fifoHead;
    logic          fifoFull;
    logic          fifoEmpty;
    logic          inAccept;
    logic          outXfer;

    logic          pop;
    logic          loadPatched;
    logic          loadPlain;
    logic          clearValid;
    logic          frameDone;
    logic          cksTake;

    assign inBeat.data = S_AXIS_TDATA;
    assign inBeat.keep = S_AXIS_TKEEP;
    assign inBeat.last = S_AXIS_TLAST;

    // A pop in the same cycle frees a slot, so a full buffer still accepts.
    assign S_AXIS_TREADY = !fifoFull || pop;
    assign inAccept      = S_AXIS_TVALID && S_AXIS_TREADY;
    assign outXfer       = outValid_q && M_AXIS_TREADY;

    // A checksum presented during reset must stay with the engine.
    assign S_CKS_TREADY  = cksTake && !rst;

    tcp_cks_beat_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i    (clk),
        .rst_i    (rst),
        .wrEn_i   (inAccept),
        .wrBeat_i (inBeat),
        .full_o   (fifoFull),
        .rdEn_i   (pop),
        .rdBeat_o (fifoHead),
        .empty_o  (fifoEmpty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!fifoEmpty && S_CKS_TVALID) begin
                    state_d = ST_HEAD;
                end
            end
            ST_HEAD: begin
                if (outXfer) begin
                    state_d = outBeat_q.last ? ST_IDLE : ST_BODY;
                end
            end
            ST_BODY: begin
                if (outXfer && outBeat_q.last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // In HEAD and BODY the output register refills from the buffer as soon
    // as it drains, giving one beat per cycle. The final beat of a frame is
    // never followed by a refill because the next frame needs its checksum.
    always_comb begin
        pop         = 1'b0;
        loadPatched = 1'b0;
        loadPlain   = 1'b0;
        clearValid  = 1'b0;
        frameDone   = 1'b0;
        cksTake     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifoEmpty && S_CKS_TVALID) begin
                    pop         = 1'b1;
                    loadPatched = 1'b1;
                    cksTake     = 1'b1;
                end
            end
            ST_HEAD, ST_BODY: begin
                if (outXfer && outBeat_q.last) begin
                    frameDone  = 1'b1;
                    clearValid = 1'b1;
                end else if (!outValid_q || outXfer) begin
                    if (!fifoEmpty) begin
                        pop       = 1'b1;
                        loadPlain = 1'b1;
                    end else begin
                        clearValid = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        outBeat_d  = outBeat_q;
        outValid_d = outValid_q;
        pktCount_d = pktCount_q + {31'd0, frameDone};
        if (loadPatched) begin
            outBeat_d      = fifoHead;
            outBeat_d.data = patchChecksum(fifoHead.data, S_CKS_TDATA, CKS_OFFSET);
            outValid_d     = 1'b1;
        end else if (loadPlain) begin
            outBeat_d  = fifoHead;
            outValid_d = 1'b1;
        end else if (clearValid) begin
            outValid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            outBeat_q  <= '0;
            outValid_q <= 1'b0;
            pktCount_q <= '0;
        end else begin
            outBeat_q  <= outBeat_d;
            outValid_q <= outValid_d;
            pktCount_q <= pktCount_d;
        end
    end

    assign M_AXIS_TDATA  = outBeat_q.data;
    assign M_AXIS_TKEEP  = outBeat_q.keep;
    assign M_AXIS_TLAST  = outBeat_q.last;
    assign M_AXIS_TVALID = outValid_q;
    assign pkt_count     = pktCount_q;

    // Beats accepted so far in the incoming frame, saturating at DEPTH.
    always_comb begin
        inBeats_d = inBeats_q;
        if (inAccept) begin
            if (S_AXIS_TLAST) begin
                inBeats_d = '0;
            end else if (inBeats_q != CW'(DEPTH)) begin
                inBeats_d = inBeats_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inBeats_q <= '0;
        end else begin
            inBeats_q <= inBeats_d;
        end
    end

    // A frame longer than the buffer can never be released and stalls the path.
    frameFitsBuffer: assert property (@(posedge clk) disable iff (rst)
        !(inAccept && (inBeats_q == CW'(DEPTH))));

endmodule

// File: tb/tb_tcp_checksum_insert.sv
// tb_tcp_checksum_insert
// Scoreboard bench for tcp_checksum_insert: stimulus pushes the expected
// output beats of each frame into a queue, an independent monitor pops
// and compares them on every output handshake and checks that a stalled
// beat holds steady.
module tb_tcp_checksum_insert;

    localparam int DEPTH    = 32;
    localparam int CKS_BYTE = 50;

    typedef struct {
        logic [511:0] data;
        logic [63:0]  keep;
        logic         last;
    } tbBeat_t;

    logic         clk;
    logic         rst;
    logic [511:0] S_AXIS_TDATA;
    logic [63:0]  S_AXIS_TKEEP;
    logic         S_AXIS_TVALID;
    logic         S_AXIS_TLAST;
    logic         S_AXIS_TREADY;
    logic [15:0]  S_CKS_TDATA;
    logic         S_CKS_TVALID;
    logic         S_CKS_TREADY;
    logic [511:0] M_AXIS_TDATA;
    logic [63:0]  M_AXIS_TKEEP;
    logic         M_AXIS_TVALID;
    logic         M_AXIS_TLAST;
    logic         M_AXIS_TREADY;
    logic [31:0]  pkt_count;

    int           errorCount = 0;
    int           checkCount = 0;
    int           readyMode  = 2;
    logic [31:0]  expPkts    = 32'd0;
    tbBeat_t      expQ[$];

    tcp_checksum_insert #(
        .DEPTH      (DEPTH),
        .CKS_OFFSET (CKS_BYTE)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .S_AXIS_TDATA  (S_AXIS_TDATA),
        .S_AXIS_TKEEP  (S_AXIS_TKEEP),
        .S_AXIS_TVALID (S_AXIS_TVALID),
        .S_AXIS_TLAST  (S_AXIS_TLAST),
        .S_AXIS_TREADY (S_AXIS_TREADY),
        .S_CKS_TDATA   (S_CKS_TDATA),
        .S_CKS_TVALID  (S_CKS_TVALID),
        .S_CKS_TREADY  (S_CKS_TREADY),
        .M_AXIS_TDATA  (M_AXIS_TDATA),
        .M_AXIS_TKEEP  (M_AXIS_TKEEP),
        .M_AXIS_TVALID (M_AXIS_TVALID),
        .M_AXIS_TLAST  (M_AXIS_TLAST),
        .M_AXIS_TREADY (M_AXIS_TREADY),
        .pkt_count     (pkt_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [511:0] actual,
                               input logic [511:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkBit(input string name, input logic actual, input logic expected);
        checkOutput(name, 512'(actual), 512'(expected));
    endtask

    task automatic checkWord(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
        checkOutput(name, 512'(actual), 512'(expected));
    endtask

    // Reference model: the checksum lands little-endian in bytes 50 and 51.
    function automatic logic [511:0] withChecksum(input logic [511:0] d, input logic [15:0] cks);
        logic [511:0] r;
        r = d;
        r[8*CKS_BYTE +: 8]     = cks[7:0];
        r[8*(CKS_BYTE+1) +: 8] = cks[15:8];
        return r;
    endfunction

    // Builds a random frame, queues its expected output, then drives it.
    // lastBytes = 0 picks a random byte count for the final beat.
    task automatic applyStimulus(input int nBeats, input logic [15:0] cks, input int lastBytes);
        tbBeat_t b;
        tbBeat_t e;
        int      nb;
        logic    accepted;
        tbBeat_t frame[$];
        for (int i = 0; i < nBeats; i++) begin
            for (int w = 0; w < 16; w++) begin
                b.data[32*w +: 32] = $urandom;
            end
            b.last = (i == nBeats - 1);
            if (b.last) begin
                nb     = (lastBytes == 0) ? int'($urandom_range(1, 64)) : lastBytes;
                b.keep = (nb == 64) ? {64{1'b1}} : ((64'd1 << nb) - 64'd1);
            end else begin
                b.keep = {64{1'b1}};
            end
            if (i == 0) begin
                b.data[8*CKS_BYTE +: 16] = 16'h0000;
            end
            e = b;
            if (i == 0) begin
                e.data = withChecksum(b.data, cks);
            end
            expQ.push_back(e);
            frame.push_back(b);
        end
        expPkts = expPkts + 32'd1;
        foreach (frame[i]) begin
            S_AXIS_TDATA  = frame[i].data;
            S_AXIS_TKEEP  = frame[i].keep;
            S_AXIS_TLAST  = frame[i].last;
            S_AXIS_TVALID = 1'b1;
            accepted      = 1'b0;
            for (int c = 0; c < 500 && !accepted; c++) begin
                @(negedge clk);
                accepted = S_AXIS_TREADY;
                @(posedge clk);
                #1;
            end
            checkBit("s_axis_accept", accepted, 1'b1);
        end
        S_AXIS_TVALID = 1'b0;
        S_AXIS_TLAST  = 1'b0;
    endtask

    task automatic sendChecksum(input logic [15:0] cks);
        logic taken;
        S_CKS_TDATA  = cks;
        S_CKS_TVALID = 1'b1;
        taken        = 1'b0;
        for (int c = 0; c < 500 && !taken; c++) begin
            @(negedge clk);
            taken = S_CKS_TREADY;
            @(posedge clk);
            #1;
        end
        S_CKS_TVALID = 1'b0;
        checkBit("cks_accept", taken, 1'b1);
    endtask

    task automatic waitDrain();
        int c;
        c = 0;
        while (expQ.size() != 0 && c < 3000) begin
            @(negedge clk);
            c++;
        end
        @(posedge clk);
        #1;
        checkWord("drain_remaining", 32'(expQ.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic checkPkts(input string name);
        checkWord(name, pkt_count, expPkts);
    endtask

    // Downstream ready: 0 = always, 1 = random, 2 = held low, 3 = driven by the test.
    initial begin
        M_AXIS_TREADY = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (readyMode)
                0:       M_AXIS_TREADY = 1'b1;
                1:       M_AXIS_TREADY = 1'($urandom_range(0, 1));
                2:       M_AXIS_TREADY = 1'b0;
                default: ;
            endcase
        end
    end

    // Monitor: compares every output handshake and checks stall stability.
    logic         held = 1'b0;
    logic [511:0] heldData;
    logic [63:0]  heldKeep;
    logic         heldLast;

    always @(negedge clk) begin
        tbBeat_t e;
        if (rst) begin
            held <= 1'b0;
        end else begin
            if (held) begin
                checkBit("stall_valid", M_AXIS_TVALID, 1'b1);
                checkOutput("stall_data", M_AXIS_TDATA, heldData);
                checkOutput("stall_keep", 512'(M_AXIS_TKEEP), 512'(heldKeep));
                checkBit("stall_last", M_AXIS_TLAST, heldLast);
            end
            if (M_AXIS_TVALID && M_AXIS_TREADY) begin
                if (expQ.size() == 0) begin
                    checkCount++;
                    errorCount++;
                    $display("[TB] FAIL unexpected_beat: got data 0x%0h, expected no beat", M_AXIS_TDATA);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("out_data", M_AXIS_TDATA, e.data);
                    checkOutput("out_keep", 512'(M_AXIS_TKEEP), 512'(e.keep));
                    checkBit("out_last", M_AXIS_TLAST, e.last);
                end
                held <= 1'b0;
            end else if (M_AXIS_TVALID) begin
                held     <= 1'b1;
                heldData <= M_AXIS_TDATA;
                heldKeep <= M_AXIS_TKEEP;
                heldLast <= M_AXIS_TLAST;
            end else begin
                held <= 1'b0;
            end
        end
    end

    initial begin
        #500000;
        errorCount++;
        checkCount++;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

    initial begin
        logic [15:0] cks;
        int          n;
        rst           = 1'b1;
        S_AXIS_TDATA  = '0;
        S_AXIS_TKEEP  = '0;
        S_AXIS_TVALID = 1'b0;
        S_AXIS_TLAST  = 1'b0;
        S_CKS_TDATA   = '0;
        S_CKS_TVALID  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] reset state");
        @(negedge clk);
        checkBit("rst_m_valid", M_AXIS_TVALID, 1'b0);
        checkOutput("rst_m_data", M_AXIS_TDATA, '0);
        checkOutput("rst_m_keep", 512'(M_AXIS_TKEEP), '0);
        checkBit("rst_m_last", M_AXIS_TLAST, 1'b0);
        checkBit("rst_cks_ready", S_CKS_TREADY, 1'b0);
        checkWord("rst_pkt_count", pkt_count, 32'd0);
        checkBit("rst_s_ready", S_AXIS_TREADY, 1'b1);
        @(posedge clk);
        #1;

        $display("[TB] single-beat frame");
        readyMode = 0;
        applyStimulus(1, 16'hBEEF, 60);
        sendChecksum(16'hBEEF);
        waitDrain();
        checkPkts("pkt_count_single");

        $display("[TB] delayed checksum");
        applyStimulus(3, 16'h5A3C, 0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checkBit("no_valid_before_cks", M_AXIS_TVALID, 1'b0);
            @(posedge clk);
            #1;
        end
        S_CKS_TDATA  = 16'h5A3C;
        S_CKS_TVALID = 1'b1;
        @(negedge clk);
        checkBit("cks_ready_pulse", S_CKS_TREADY, 1'b1);
        checkBit("valid_low_load_cycle", M_AXIS_TVALID, 1'b0);
        @(posedge clk);
        #1;
        S_CKS_TVALID = 1'b0;
        @(negedge clk);
        checkBit("valid_after_one_cycle", M_AXIS_TVALID, 1'b1);
        checkBit("cks_ready_one_cycle", S_CKS_TREADY, 1'b0);
        @(posedge clk);
        #1;
        waitDrain();
        checkPkts("pkt_count_delayed");

        $display("[TB] back-to-back frames with random ready");
        readyMode = 1;
        applyStimulus(2, 16'h1234, 0);
        sendChecksum(16'h1234);
        applyStimulus(2, 16'hABCD, 0);
        sendChecksum(16'hABCD);
        waitDrain();
        checkPkts("pkt_count_b2b");

        $display("[TB] full buffer");
        readyMode = 2;
        applyStimulus(DEPTH, 16'h7E81, 0);
        @(negedge clk);
        checkBit("full_s_ready_low", S_AXIS_TREADY, 1'b0);
        checkBit("full_no_output", M_AXIS_TVALID, 1'b0);
        @(posedge clk);
        #1;
        readyMode = 0;
        sendChecksum(16'h7E81);
        waitDrain();
        checkPkts("pkt_count_full");

        $display("[TB] checksum with empty buffer");
        S_CKS_TDATA  = 16'h0F1E;
        S_CKS_TVALID = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checkBit("empty_cks_ready", S_CKS_TREADY, 1'b0);
            checkBit("empty_no_output", M_AXIS_TVALID, 1'b0);
            @(posedge clk);
            #1;
        end
        fork
            applyStimulus(1, 16'h0F1E, 0);
            sendChecksum(16'h0F1E);
        join
        waitDrain();
        checkPkts("pkt_count_early_cks");

        $display("[TB] random frames");
        readyMode = 1;
        for (int f = 0; f < 20; f++) begin
            n   = int'($urandom_range(1, 6));
            cks = 16'($urandom);
            applyStimulus(n, cks, 0);
            repeat ($urandom_range(0, 5)) begin
                @(posedge clk);
                #1;
            end
            sendChecksum(cks);
        end
        waitDrain();
        checkPkts("pkt_count_random");

        $display("[TB] reset during body");
        readyMode = 2;
        @(posedge clk);
        #1;
        readyMode = 3;
        applyStimulus(4, 16'h2468, 0);
        sendChecksum(16'h2468);
        M_AXIS_TREADY = 1'b1;
        @(posedge clk);
        #1;
        M_AXIS_TREADY = 1'b0;
        rst = 1'b1;
        expQ.delete();
        expPkts = 32'd0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkBit("midrst_m_valid", M_AXIS_TVALID, 1'b0);
        checkOutput("midrst_m_data", M_AXIS_TDATA, '0);
        checkOutput("midrst_m_keep", 512'(M_AXIS_TKEEP), '0);
        checkBit("midrst_m_last", M_AXIS_TLAST, 1'b0);
        checkWord("midrst_pkt_count", pkt_count, 32'd0);
        checkBit("midrst_s_ready", S_AXIS_TREADY, 1'b1);
        readyMode = 0;
        S_CKS_TDATA  = 16'hC0DE;
        S_CKS_TVALID = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkBit("midrst_buffer_empty", S_CKS_TREADY, 1'b0);
            checkBit("midrst_no_output", M_AXIS_TVALID, 1'b0);
            @(posedge clk);
            #1;
        end
        fork
            applyStimulus(2, 16'hC0DE, 0);
            sendChecksum(16'hC0DE);
        join
        waitDrain();
        checkPkts("pkt_count_after_rst");

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
